msdap_alu: RTL and testbench

Per-channel filter datapath of the MSDAP. It sits directly downstream of the Rj, coefficient and data memories. On each `start` it walks the 16 Rj groups and their coefficients, and reads delayed samples from the data memory. It accumulates ±x(n−k) per group, applies the shift-add recurrence y = (y + u) >>> 1 per group, and presents the 40-bit result with a one-cycle `done` pulse. One instance serves the left channel and one the right.

---
 rtl/msdap_alu.sv | 142 ++++++++++++++
 tb/tb_msdap_alu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msdap_alu.sv
// msdap_alu: per-channel MSDAP filter datapath (Rj walk, accumulate, shift-add).
// Define MSDAP_ALU_SAT_EN to saturate the group accumulator u instead of wrapping.
module msdap_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  newest_addr,
  input  logic        sample_wr,
  input  logic        clear,
  output logic [3:0]  rj_addr,
  input  logic [15:0] rj_data,
  output logic [8:0]  coeff_addr,
  input  logic [15:0] coeff_data,
  output logic [7:0]  data_addr,
  input  logic [15:0] data_in,
  output logic [39:0] y_out,
  output logic        busy,
  output logic        done
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ACC   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [8:0]  r_scnt;
  logic [8:0]  r_cnt;
  logic [8:0]  r_ptr;
  logic [7:0]  r_newest;
  logic [3:0]  r_j;
  logic [39:0] r_y;
  logic [39:0] r_u;
  logic [39:0] r_yout;

  logic [7:0]  w_k;
  logic        w_take;
  logic [39:0] w_x40;
  logic [39:0] w_u_nxt;
  logic [40:0] w_ysum;
  logic [39:0] w_y_nxt;
  logic        w_unused;

  assign w_k     = coeff_data[7:0];
  assign w_take  = ({1'b0, w_k} < r_scnt);
  assign w_x40   = {{8{data_in[15]}}, data_in, 16'h0};
  assign w_ysum  = {r_y[39], r_y} + {r_u[39], r_u};
  assign w_y_nxt = w_ysum[40:1];

`ifdef MSDAP_ALU_SAT_EN
  logic [40:0] w_usum;
  assign w_usum = coeff_data[8]
    ? {r_u[39], r_u} - {w_x40[39], w_x40}
    : {r_u[39], r_u} + {w_x40[39], w_x40};
  // clamp the 41-bit sum into the signed 40-bit range
  always_comb begin
    w_u_nxt = w_usum[39:0];
    if (w_usum[40] != w_usum[39])
      w_u_nxt = w_usum[40] ? {1'b1, 39'h0}
                           : {1'b0, {39{1'b1}}};
  end
`else
  assign w_u_nxt = coeff_data[8] ? r_u - w_x40
                                 : r_u + w_x40;
`endif

  assign w_unused = ^{rj_data[15:9], coeff_data[15:9],
                      w_ysum[0]};

  assign rj_addr    = r_j;
  assign coeff_addr = r_ptr;
  assign data_addr  = (r_state == S_ACC) ? r_newest - w_k
                                         : 8'd0;
  assign y_out      = r_yout;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

  // count of samples in the data memory, saturating at 256
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_scnt <= '0;
    else if (clear)
      r_scnt <= '0;
    else if (sample_wr && r_scnt != 9'd256)
      r_scnt <= r_scnt + 9'd1;
  end

  // group walk: load count, accumulate terms, shift-add, publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_newest <= '0;
      r_j      <= '0;
      r_y      <= '0;
      r_u      <= '0;
      r_yout   <= '0;
    end else if (clear) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_newest <= newest_addr;
            r_y      <= '0;
            r_u      <= '0;
            r_j      <= '0;
            r_ptr    <= '0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= rj_data[8:0];
          r_state <= (rj_data[8:0] == 9'd0) ? S_SHIFT
                                            : S_ACC;
        end
        S_ACC: begin
          if (w_take)
            r_u <= w_u_nxt;
          r_ptr <= r_ptr + 9'd1;
          r_cnt <= r_cnt - 9'd1;
          if (r_cnt == 9'd1)
            r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_y <= w_y_nxt;
          r_u <= '0;
          if (r_j == 4'd15) begin
            r_yout  <= w_y_nxt;
            r_state <= S_DONE;
          end else begin
            r_j     <= r_j + 4'd1;
            r_state <= S_LOAD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msdap_alu.sv
// tb_msdap_alu: randomized and directed checks of msdap_alu
// against a plain-arithmetic filter model.
module tb_msdap_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  newest_addr = 8'd0;
  logic        sample_wr = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  rj_addr;
  logic [15:0] rj_data;
  logic [8:0]  coeff_addr;
  logic [15:0] coeff_data;
  logic [7:0]  data_addr;
  logic [15:0] data_in;
  logic [39:0] y_out;
  logic        busy;
  logic        done;

  logic [15:0] rj_mem [16];
  logic [15:0] coeff_mem [512];
  logic [15:0] data_mem [256];

  int         n_chk = 0;
  int         n_err = 0;
  int         sc = 0;
  logic [7:0] nw = 8'd0;
  logic [7:0] last_da;
  logic [39:0] y_prev;

  assign rj_data    = rj_mem[rj_addr];
  assign coeff_data = coeff_mem[coeff_addr];
  assign data_in    = data_mem[data_addr];

  msdap_alu dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .newest_addr(newest_addr), .sample_wr(sample_wr),
    .clear(clear), .rj_addr(rj_addr), .rj_data(rj_data),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .data_addr(data_addr), .data_in(data_in),
    .y_out(y_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic longint fix40(input longint v);
    longint r;
    r = v;
`ifdef MSDAP_ALU_SAT_EN
    if (r > (longint'(1) <<< 39) - 1) r = (longint'(1) <<< 39) - 1;
    else if (r < -(longint'(1) <<< 39)) r = -(longint'(1) <<< 39);
`else
    r = r & ((longint'(1) <<< 40) - 1);
    if (r >= (longint'(1) <<< 39)) r = r - (longint'(1) <<< 40);
`endif
    return r;
  endfunction

  function automatic longint model_y(input logic [7:0] nwa,
                                     input int scnt);
    longint y, u, x;
    int p, k, n;
    logic [15:0] c;
    y = 0;
    p = 0;
    for (int j = 0; j < 16; j++) begin
      u = 0;
      n = int'(rj_mem[j][8:0]);
      for (int t = 0; t < n; t++) begin
        c = coeff_mem[p];
        p = (p + 1) % 512;
        k = int'(c[7:0]);
        if (k < scnt) begin
          x = longint'($signed(data_mem[(int'(nwa) - k + 256) % 256]));
          x = x * 65536;
          u = c[8] ? u - x : u + x;
          u = fix40(u);
        end
      end
      y = (y + u) >>> 1;
    end
    return y;
  endfunction

  function automatic int sum_rj();
    int s;
    s = 0;
    for (int j = 0; j < 16; j++) s += int'(rj_mem[j][8:0]);
    return s;
  endfunction

  task automatic clr_rj();
    for (int j = 0; j < 16; j++) rj_mem[j] = 16'h0;
  endtask

  task automatic wr_sample(input logic [7:0] a, input logic [15:0] v);
    @(negedge clk);
    data_mem[a] = v;
    nw = a;
    sample_wr = 1'b1;
    @(negedge clk);
    sample_wr = 1'b0;
    if (sc < 256) sc++;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sc = 0;
  endtask

  task automatic run(input string tag, input bit dbl);
    int n, s;
    longint e;
    logic [7:0] da;
    s = sum_rj();
    e = model_y(nw, sc);
    @(negedge clk);
    newest_addr = nw;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    da = 8'd0;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1 n++;
      if (data_addr != 8'd0) da = data_addr;
      start = (dbl && n == 3);
    end
    start = 1'b0;
    last_da = da;
    chk({tag, "_lat"}, n, s + 32);
    chk({tag, "_y"}, y_out, e[39:0]);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {busy, done}, 2'b00);
    y_prev = y_out;
  endtask

  initial begin
    int ndone;
    logic [31:0] r;
    for (int i = 0; i < 512; i++) coeff_mem[i] = 16'h0;
    for (int i = 0; i < 256; i++) data_mem[i] = 16'h0;
    clr_rj();

    repeat (3) @(negedge clk);
    chk("rst_y", y_out, 40'h0);
    chk("rst_bd", {busy, done}, 2'b00);
    chk("rst_addr", {rj_addr, coeff_addr, data_addr}, 21'h0);
    rst_n = 1'b1;

    run("allzero", 1'b0);

    wr_sample(8'd10, 16'h4000);
    rj_mem[15] = 16'd1;
    run("rj15", 1'b0);
    chk("rj15_const", y_out, 40'h00_2000_0000);

    rj_mem[15] = 16'd0;
    rj_mem[0]  = 16'd1;
    coeff_mem[0] = 16'h100;
    run("neg", 1'b0);
    chk("neg_const", y_out, 40'hFF_FFFF_C000);

    do_clear();
    wr_sample(8'd255, 16'h4000);
    clr_rj();
    rj_mem[15] = 16'd1;
    coeff_mem[0] = 16'h001;
    run("gate", 1'b0);
    chk("gate_const", y_out, 40'h0);
    chk("gate_da", last_da, 8'd254);
    wr_sample(8'd0, 16'h1234);
    run("take", 1'b0);
    chk("take_const", y_out, 40'h00_2000_0000);
    chk("take_da", last_da, 8'd255);

    run("dblstart", 1'b1);

    do_clear();
    for (int i = 0; i < 256; i++) data_mem[i] = 16'($urandom);
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 512; i++) coeff_mem[i] = 16'($urandom);
      for (int j = 0; j < 16; j++) begin
        r = $urandom;
        if (it == 7) rj_mem[j] = {r[15:9], 9'd40};
        else rj_mem[j] = {r[15:9], 9'($urandom_range(0, 6))};
      end
      for (int s = 0; s < int'($urandom_range(1, 40)); s++)
        wr_sample(nw + 8'd1, 16'($urandom));
      run($sformatf("rnd%0d", it), 1'b0);
    end

    clr_rj();
    rj_mem[15] = 16'd511;
    for (int i = 0; i < 512; i++) coeff_mem[i] = 16'h0;
    wr_sample(nw + 8'd1, 16'h7FFF);
    run("sat", 1'b0);
`ifdef MSDAP_ALU_SAT_EN
    chk("sat_const", y_out, 40'h3F_FFFF_FFFF);
`endif

    rj_mem[15] = 16'd100;
    @(negedge clk);
    newest_addr = nw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (45) @(negedge clk);
    chk("clr_busy0", busy, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sc = 0;
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    chk("clr_done", ndone, 0);
    chk("clr_busy", busy, 1'b0);
    chk("clr_yhold", y_out, y_prev);

    wr_sample(nw + 8'd1, 16'h4000);
    @(negedge clk);
    newest_addr = nw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_y", y_out, 40'h0);
    chk("arst_bd", {busy, done}, 2'b00);
    chk("arst_addr", {rj_addr, coeff_addr, data_addr}, 21'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sc = 0;
    clr_rj();
    rj_mem[15] = 16'd1;
    run("arst_cnt", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
